// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller is the master: it takes the decoded IR fields and Zero, and drives every datapath strobe.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCEn;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtSel;
  logic [3:0] ALUOperation;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output PCEn, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtSel,
           ALUOperation, Illegal, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  PCEn, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtSel,
           ALUOperation, Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath; 2-5 cycles per instruction, no backpressure.
// Strobes are registered from the next state so they change cleanly on the clock edge.
module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JR        = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_t;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtSel;
    logic [3:0] ALUOperation;
  } ctl_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_BEQ = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Opcode/Funct are sampled on the edge entering a state, so they only need to be stable from DECODE on.
  function automatic ctl_t f_ctl(input state_t s, input logic [5:0] opc, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.MemRead      = 1'b1;
        c.IRWrite      = 1'b1;
        c.ALUSrcB      = 2'b01;
        c.ALUOperation = ALU_ADD;
        c.PCWrite      = 1'b1;
      end
      S_DECODE: begin
        c.ALUSrcB      = 2'b11;
        c.ALUOperation = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.ALUSrcA      = 1'b1;
        c.ALUSrcB      = 2'b10;
        c.ALUOperation = ALU_ADD;
      end
      S_MEM_READ: begin
        c.MemRead = 1'b1;
        c.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        c.RegWrite = 1'b1;
        c.MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.MemWrite = 1'b1;
        c.IorD     = 1'b1;
      end
      S_R_EXEC: begin
        c.ALUSrcA = 1'b1;
        case (fn)
          FN_SLL:  c.ALUOperation = ALU_SLL;
          FN_SRL:  c.ALUOperation = ALU_SRL;
          FN_SUB:  c.ALUOperation = ALU_SUB;
          FN_AND:  c.ALUOperation = ALU_AND;
          FN_OR:   c.ALUOperation = ALU_OR;
          FN_NOR:  c.ALUOperation = ALU_NOR;
          default: c.ALUOperation = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        c.RegWrite = 1'b1;
        c.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        c.ALUSrcA      = 1'b1;
        c.ALUOperation = (opc == OP_BNE) ? ALU_BNE : ALU_BEQ;
        c.PCWriteCond  = 1'b1;
        c.PCSource     = 2'b01;
      end
      S_JUMP: begin
        c.PCWrite  = 1'b1;
        c.PCSource = 2'b10;
      end
      S_JR: begin
        c.PCWrite  = 1'b1;
        c.PCSource = 2'b11;
      end
      S_I_EXEC: begin
        c.ALUSrcA = 1'b1;
        c.ALUSrcB = 2'b10;
        c.ExtSel  = (opc != OP_ADDI);
        case (opc)
          OP_ANDI: c.ALUOperation = ALU_AND;
          OP_ORI:  c.ALUOperation = ALU_OR;
          OP_LUI:  c.ALUOperation = ALU_LUI;
          default: c.ALUOperation = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        c.RegWrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t                 r_state;
  ctl_t                   r_ctl;
  logic [COUNT_WIDTH-1:0] r_count;
  state_t                 w_dec_target;
  state_t                 w_next;
  logic                   w_legal;

  always_comb begin
    w_dec_target = S_FETCH;
    case (bus.Opcode)
      OP_LW, OP_SW:                     w_dec_target = S_MEM_ADDR;
      OP_BEQ, OP_BNE:                   w_dec_target = S_BRANCH;
      OP_J:                             w_dec_target = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_dec_target = S_I_EXEC;
      OP_RTYPE: begin
        case (bus.Funct)
          FN_JR:                                                 w_dec_target = S_JR;
          FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR: w_dec_target = S_R_EXEC;
          default:                                               w_dec_target = S_FETCH;
        endcase
      end
      default: w_dec_target = S_FETCH;
    endcase
  end

  // Every supported instruction leaves DECODE for a non-FETCH state.
  assign w_legal = (w_dec_target != S_FETCH);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = w_dec_target;
      S_MEM_ADDR: w_next = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: w_next = S_MEM_WB;
      S_R_EXEC:   w_next = S_R_WB;
      S_I_EXEC:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ctl   <= f_ctl(S_FETCH, 6'h00, 6'h00);
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= f_ctl(w_next, bus.Opcode, bus.Funct);
      if (r_state == S_FETCH) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.PCWrite      = r_ctl.PCWrite;
  assign bus.PCWriteCond  = r_ctl.PCWriteCond;
  assign bus.PCSource     = r_ctl.PCSource;
  assign bus.IorD         = r_ctl.IorD;
  assign bus.MemRead      = r_ctl.MemRead;
  assign bus.MemWrite     = r_ctl.MemWrite;
  assign bus.IRWrite      = r_ctl.IRWrite;
  assign bus.RegWrite     = r_ctl.RegWrite;
  assign bus.RegDst       = r_ctl.RegDst;
  assign bus.MemtoReg     = r_ctl.MemtoReg;
  assign bus.ALUSrcA      = r_ctl.ALUSrcA;
  assign bus.ALUSrcB      = r_ctl.ALUSrcB;
  assign bus.ExtSel       = r_ctl.ExtSel;
  assign bus.ALUOperation = r_ctl.ALUOperation;
  // A Zero glitch outside BRANCH is harmless because PCWriteCond is low there.
  assign bus.PCEn         = r_ctl.PCWrite | (r_ctl.PCWriteCond & bus.Zero);
  assign bus.Illegal      = (r_state == S_DECODE) && !w_legal;
  assign bus.State        = r_state;
  assign InstrCount       = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] icnt;
  int          total = 0;
  int          bad = 0;

  multicycle_control_if bus();

  multicycle_control #(.COUNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus),
    .InstrCount (icnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extsel;
    logic [3:0] aluop;
    logic       illegal;
    logic       pcen;
  } tctl_t;

  typedef int iq_t[$];

  // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 jr, 4 branch, 5 j, 6 I-type, 7 illegal
  function automatic int classify(logic [5:0] opc, logic [5:0] fn);
    case (opc)
      6'h23: return 0;
      6'h2B: return 1;
      6'h00: begin
        if (fn == 6'h08) return 3;
        if (fn inside {6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27}) return 2;
        return 7;
      end
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      6'h08, 6'h0C, 6'h0D, 6'h0F: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic iq_t exp_seq(int c);
    iq_t q;
    q.push_back(0);
    q.push_back(1);
    case (c)
      0: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      1: begin q.push_back(2); q.push_back(5); end
      2: begin q.push_back(6); q.push_back(7); end
      3: q.push_back(10);
      4: q.push_back(8);
      5: q.push_back(9);
      6: begin q.push_back(11); q.push_back(12); end
      default: ;
    endcase
    return q;
  endfunction

  function automatic tctl_t exp_ctl(int st, logic [5:0] opc, logic [5:0] fn, logic z);
    tctl_t e;
    e = '0;
    case (st)
      0: begin e.memread = 1; e.irwrite = 1; e.alusrcb = 2'b01; e.aluop = 4'd3; e.pcwrite = 1; end
      1: begin e.alusrcb = 2'b11; e.aluop = 4'd3; e.illegal = (classify(opc, fn) == 7); end
      2: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 4'd3; end
      3: begin e.memread = 1; e.iord = 1; end
      4: begin e.regwrite = 1; e.memtoreg = 1; end
      5: begin e.memwrite = 1; e.iord = 1; end
      6: begin
        e.alusrca = 1;
        case (fn)
          6'h00: e.aluop = 4'd6;
          6'h02: e.aluop = 4'd7;
          6'h20: e.aluop = 4'd3;
          6'h22: e.aluop = 4'd4;
          6'h24: e.aluop = 4'd0;
          6'h25: e.aluop = 4'd1;
          default: e.aluop = 4'd2;
        endcase
      end
      7: begin e.regwrite = 1; e.regdst = 1; end
      8: begin e.alusrca = 1; e.aluop = (opc == 6'h04) ? 4'd8 : 4'd9; e.pcwritecond = 1; e.pcsource = 2'b01; end
      9: begin e.pcwrite = 1; e.pcsource = 2'b10; end
      10: begin e.pcwrite = 1; e.pcsource = 2'b11; end
      11: begin
        e.alusrca = 1;
        e.alusrcb = 2'b10;
        case (opc)
          6'h08: begin e.extsel = 0; e.aluop = 4'd3; end
          6'h0C: begin e.extsel = 1; e.aluop = 4'd0; end
          6'h0D: begin e.extsel = 1; e.aluop = 4'd1; end
          default: begin e.extsel = 1; e.aluop = 4'd5; end
        endcase
      end
      12: e.regwrite = 1;
      default: ;
    endcase
    e.pcen = e.pcwrite | (e.pcwritecond & z);
    return e;
  endfunction

  function automatic tctl_t observe();
    tctl_t o;
    o.pcwrite = bus.PCWrite;   o.pcwritecond = bus.PCWriteCond; o.pcsource = bus.PCSource;
    o.iord = bus.IorD;         o.memread = bus.MemRead;         o.memwrite = bus.MemWrite;
    o.irwrite = bus.IRWrite;   o.regwrite = bus.RegWrite;       o.regdst = bus.RegDst;
    o.memtoreg = bus.MemtoReg; o.alusrca = bus.ALUSrcA;         o.alusrcb = bus.ALUSrcB;
    o.extsel = bus.ExtSel;     o.aluop = bus.ALUOperation;      o.illegal = bus.Illegal;
    o.pcen = bus.PCEn;
    return o;
  endfunction

  int    obs_st [12];
  tctl_t obs_ctl[12];
  logic  obs_z  [12];
  int    obs_n;

  // Runs one instruction from FETCH until the next FETCH (bounded), capturing each cycle.
  task automatic exec(input logic [5:0] opc, input logic [5:0] fn, input int zmode);
    bus.Opcode = opc;
    bus.Funct  = fn;
    obs_n = 0;
    do begin
      bus.Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      obs_st[obs_n]  = int'(bus.State);
      obs_ctl[obs_n] = observe();
      obs_z[obs_n]   = bus.Zero;
      obs_n++;
      @(posedge clk); #1;
    end while (bus.State != 4'd0 && obs_n < 10);
  endtask

  task automatic test_reset();
    tctl_t e;
    rst_n = 1'b0;
    bus.Opcode = 6'h02; bus.Funct = 6'h00; bus.Zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      e = exp_ctl(0, 6'h02, 6'h00, 1'b0);
      total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.State); end
      total++; if (icnt !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", icnt); end
      total++; if (observe() !== e) begin bad++; $display("FAIL reset_ctl got=%h want=%h", observe(), e); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL reset_first_edge got=%0d want=1", bus.State); end
    total++; if (icnt !== 16'd1) begin bad++; $display("FAIL reset_first_count got=%0d want=1", icnt); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL reset_jump_return got=%0d want=0", bus.State); end
  endtask

  task automatic test_mem();
    iq_t q; tctl_t e; logic [15:0] c0; logic [5:0] ops [2];
    ops[0] = 6'h23; ops[1] = 6'h2B;
    for (int i = 0; i < 2; i++) begin
      c0 = icnt;
      exec(ops[i], 6'($urandom), 2);
      q = exp_seq(classify(ops[i], 6'h00));
      total++; if (obs_n !== q.size()) begin bad++; $display("FAIL mem_len op=%h got=%0d want=%0d", ops[i], obs_n, q.size()); end
      for (int k = 0; k < obs_n && k < q.size(); k++) begin
        e = exp_ctl(q[k], ops[i], 6'h00, obs_z[k]);
        total++; if (obs_st[k] !== q[k]) begin bad++; $display("FAIL mem_state[%0d] got=%0d want=%0d", k, obs_st[k], q[k]); end
        total++; if (obs_ctl[k] !== e) begin bad++; $display("FAIL mem_ctl[%0d] got=%h want=%h", k, obs_ctl[k], e); end
      end
      total++; if (icnt !== c0 + 16'd1) begin bad++; $display("FAIL mem_count got=%0d want=%0d", icnt, c0 + 16'd1); end
    end
  endtask

  task automatic test_rtype();
    iq_t q; tctl_t e;
    exec(6'h00, 6'h22, 2);
    q = exp_seq(2);
    total++; if (obs_n !== q.size()) begin bad++; $display("FAIL sub_len got=%0d want=%0d", obs_n, q.size()); end
    for (int k = 0; k < obs_n && k < q.size(); k++) begin
      e = exp_ctl(q[k], 6'h00, 6'h22, obs_z[k]);
      total++; if (obs_st[k] !== q[k]) begin bad++; $display("FAIL sub_state[%0d] got=%0d want=%0d", k, obs_st[k], q[k]); end
      total++; if (obs_ctl[k] !== e) begin bad++; $display("FAIL sub_ctl[%0d] got=%h want=%h", k, obs_ctl[k], e); end
    end
    total++; if (obs_ctl[2].aluop !== 4'b0100) begin bad++; $display("FAIL sub_aluop got=%b want=0100", obs_ctl[2].aluop); end
    total++; if ({obs_ctl[3].regwrite, obs_ctl[3].regdst} !== 2'b11) begin bad++; $display("FAIL sub_wb got=%b want=11", {obs_ctl[3].regwrite, obs_ctl[3].regdst}); end
  endtask

  task automatic test_branch();
    iq_t q; tctl_t e; logic [5:0] opc;
    for (int i = 0; i < 4; i++) begin
      opc = (i < 2) ? 6'h05 : 6'h04;
      exec(opc, 6'($urandom), (i % 2 == 0) ? 1 : 0);
      q = exp_seq(4);
      total++; if (obs_n !== 3) begin bad++; $display("FAIL br_len op=%h got=%0d want=3", opc, obs_n); end
      for (int k = 0; k < obs_n && k < q.size(); k++) begin
        e = exp_ctl(q[k], opc, 6'h00, obs_z[k]);
        total++; if (obs_st[k] !== q[k]) begin bad++; $display("FAIL br_state[%0d] got=%0d want=%0d", k, obs_st[k], q[k]); end
        total++; if (obs_ctl[k] !== e) begin bad++; $display("FAIL br_ctl[%0d] got=%h want=%h", k, obs_ctl[k], e); end
      end
      total++; if (obs_ctl[2].pcen !== (i % 2 == 0)) begin bad++; $display("FAIL br_pcen op=%h got=%b want=%b", opc, obs_ctl[2].pcen, (i % 2 == 0)); end
    end
  endtask

  task automatic test_itype();
    iq_t q; tctl_t e; logic [5:0] ops [4]; logic [3:0] want [4];
    ops[0] = 6'h0D; ops[1] = 6'h0F; ops[2] = 6'h08; ops[3] = 6'h0C;
    want[0] = 4'b0001; want[1] = 4'b0101; want[2] = 4'b0011; want[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exec(ops[i], 6'($urandom), 2);
      q = exp_seq(6);
      total++; if (obs_n !== q.size()) begin bad++; $display("FAIL imm_len op=%h got=%0d want=%0d", ops[i], obs_n, q.size()); end
      for (int k = 0; k < obs_n && k < q.size(); k++) begin
        e = exp_ctl(q[k], ops[i], 6'h00, obs_z[k]);
        total++; if (obs_st[k] !== q[k]) begin bad++; $display("FAIL imm_state[%0d] got=%0d want=%0d", k, obs_st[k], q[k]); end
        total++; if (obs_ctl[k] !== e) begin bad++; $display("FAIL imm_ctl[%0d] got=%h want=%h", k, obs_ctl[k], e); end
      end
      total++; if (obs_ctl[2].aluop !== want[i]) begin bad++; $display("FAIL imm_aluop op=%h got=%b want=%b", ops[i], obs_ctl[2].aluop, want[i]); end
    end
  endtask

  task automatic test_illegal();
    int ill; int wr;
    exec(6'h3F, 6'h00, 2);
    ill = 0; wr = 0;
    for (int k = 0; k < obs_n; k++) begin
      ill += int'(obs_ctl[k].illegal);
      wr  += int'(obs_ctl[k].regwrite | obs_ctl[k].memwrite);
    end
    total++; if (obs_n !== 2) begin bad++; $display("FAIL ill_len got=%0d want=2", obs_n); end
    total++; if (ill !== 1) begin bad++; $display("FAIL ill_pulses got=%0d want=1", ill); end
    total++; if (obs_ctl[1].illegal !== 1'b1) begin bad++; $display("FAIL ill_decode got=%b want=1", obs_ctl[1].illegal); end
    total++; if (wr !== 0) begin bad++; $display("FAIL ill_writes got=%0d want=0", wr); end
  endtask

  task automatic test_random();
    iq_t q; tctl_t e; logic [5:0] opc, fn; logic [15:0] c0;
    logic [5:0] op_tab [10]; logic [5:0] fn_tab [8];
    op_tab = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0F};
    fn_tab = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h08};
    for (int i = 0; i < 60; i++) begin
      opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 9)];
      fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 7)];
      c0 = icnt;
      exec(opc, fn, 2);
      q = exp_seq(classify(opc, fn));
      total++; if (obs_n !== q.size()) begin bad++; $display("FAIL rnd_len op=%h fn=%h got=%0d want=%0d", opc, fn, obs_n, q.size()); end
      for (int k = 0; k < obs_n && k < q.size(); k++) begin
        e = exp_ctl(q[k], opc, fn, obs_z[k]);
        total++; if (obs_st[k] !== q[k]) begin bad++; $display("FAIL rnd_state op=%h fn=%h [%0d] got=%0d want=%0d", opc, fn, k, obs_st[k], q[k]); end
        total++; if (obs_ctl[k] !== e) begin bad++; $display("FAIL rnd_ctl op=%h fn=%h [%0d] got=%h want=%h", opc, fn, k, obs_ctl[k], e); end
      end
      total++; if (icnt !== c0 + 16'd1) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", icnt, c0 + 16'd1); end
    end
  endtask

  task automatic test_reset_mid();
    bus.Opcode = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'b0;
    for (int i = 0; i < 6 && bus.State != 4'd5; i++) begin @(posedge clk); #1; end
    total++; if (bus.MemWrite !== 1'b1) begin bad++; $display("FAIL mid_pre_memwrite got=%b want=1", bus.MemWrite); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.MemWrite !== 1'b0) begin bad++; $display("FAIL mid_memwrite got=%b want=0", bus.MemWrite); end
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", bus.State); end
    total++; if (icnt !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", icnt); end
    total++; if (bus.RegWrite !== 1'b0) begin bad++; $display("FAIL mid_regwrite got=%b want=0", bus.RegWrite); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.Opcode = 6'h3F;
    @(posedge clk); #1;
    total++; if (bus.State !== 4'd1 || bus.Illegal !== 1'b1) begin bad++; $display("FAIL mid_restart got=%0d/%b want=1/1", bus.State, bus.Illegal); end
    @(posedge clk); #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL mid_return got=%0d want=0", bus.State); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mem();
    test_rtype();
    test_branch();
    test_itype();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
